// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared constants and byte-lane sizing for the SRAM pin-bus model
package sram_ctrl_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ADDR_W = 18;

    function automatic int be_w(input int data_w);
        return (data_w / 8 > 0) ? data_w / 8 : 1;
    endfunction

endpackage

// File: rtl/sram_ctrl_mem.sv
// rtl/sram_ctrl_mem.sv - byte-lane storage with per-lane write enable and write-through merge
module sram_ctrl_mem
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int IDX_W  = DEFAULT_ADDR_W,
    parameter int DEPTH  = 2 ** IDX_W,
    parameter int BE_W   = be_w(DATA_W)
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic              merge_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [BE_W-1:0]   be_i,
    output logic [DATA_W-1:0] word_o
);

    // Narrow words (<8 bits) collapse to a single lane covering the whole word.
    localparam int LANE_W = (DATA_W < 8) ? DATA_W : 8;

    for (genvar g = 0; g < BE_W; g++) begin : g_lane
        logic [LANE_W-1:0] lane_q [DEPTH];
        logic [LANE_W-1:0] stored;

        assign stored = lane_q[idx_i];

        always_ff @(posedge clk_i) begin
            if (wr_en_i && be_i[g]) begin
                lane_q[idx_i] <= wdata_i[g*LANE_W +: LANE_W];
            end
        end

        // During a write the captured word must already reflect the lanes being written.
        assign word_o[g*LANE_W +: LANE_W] = (merge_i && be_i[g]) ? wdata_i[g*LANE_W +: LANE_W]
                                                                 : stored;
    end

endmodule

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - async-SRAM pin-bus block with cycle-counted read latency; optional SRAM_CTRL_PROTO_CHK_EN bus checks
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int   DATA_W = DEFAULT_DATA_W,
    parameter int   ADDR_W = DEFAULT_ADDR_W,
    parameter int   DEPTH  = 2 ** ADDR_W,
    localparam int  BE_W   = be_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cs_n,
    input  logic              we_n,
    input  logic              oe_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output wire  [DATA_W-1:0] rdata,
    input  logic [BE_W-1:0]   be
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic              in_range;
    logic              wr_req;
    logic [DATA_W-1:0] mem_word;
    logic [DATA_W-1:0] rd_d;
    logic [DATA_W-1:0] rd_q;

    assign in_range = ({1'b0, addr} < DEPTH_L);
    assign wr_req   = !cs_n && !we_n;

    sram_ctrl_mem #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W),
        .DEPTH  (DEPTH),
        .BE_W   (BE_W)
    ) u_mem (
        .clk_i   (clk),
        .wr_en_i (wr_req && in_range),
        .merge_i (wr_req),
        .idx_i   (addr[IDX_W-1:0]),
        .wdata_i (wdata),
        .be_i    (be),
        .word_o  (mem_word)
    );

    always_comb begin
        rd_d = '0;
        if (in_range) begin
            rd_d = mem_word;
        end
    end

    // Every selected edge captures; a write edge captures the merged post-write word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_q <= '0;
        end else if (!cs_n) begin
            rd_q <= rd_d;
        end
    end

    assign rdata = (!cs_n && we_n && !oe_n) ? rd_q : 'z;

`ifdef SRAM_CTRL_PROTO_CHK_EN
    always @(posedge clk) begin
        if (rstn && !cs_n) begin
            if (!we_n && !oe_n) begin
                $error("sram_ctrl: we_n and oe_n both low while selected");
            end
            if ($isunknown(addr) || $isunknown(be)) begin
                $error("sram_ctrl: unknown addr or be while selected");
            end
            if (!in_range) begin
                $error("sram_ctrl: addr %0h beyond DEPTH while selected", addr);
            end
        end
    end
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - directed and randomized checks of sram_ctrl against a byte-merge reference model
module tb_sram_ctrl;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 18;
    localparam int DEPTH  = 4096;
    localparam logic [15:0] RELEASED = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cs_n;
    logic        we_n;
    logic        oe_n;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    wire  [15:0] rdata;

    int tests = 0;
    int fails = 0;

    logic [15:0] ref_mem [int];

    // A released bus floats to the pull level, so high-Z reads back as all ones.
    pullup (rdata);

    always #5 clk = ~clk;

    sram_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .cs_n  (cs_n),
        .we_n  (we_n),
        .oe_n  (oe_n),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .be    (be)
    );

    function automatic logic [15:0] lane_merge(input logic [15:0] old_w, input logic [15:0] new_w,
                                               input logic [1:0] b);
        logic [15:0] mask;
        mask = 16'h0000;
        if (b[0]) mask = mask | 16'h00FF;
        if (b[1]) mask = mask | 16'hFF00;
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int a, input logic [15:0] d, input logic [1:0] b);
        cs_n  = 1'b0;
        we_n  = 1'b0;
        oe_n  = 1'b1;
        addr  = 18'(a);
        wdata = d;
        be    = b;
        tick();
        if (a < DEPTH) begin
            if (ref_mem.exists(a)) ref_mem[a] = lane_merge(ref_mem[a], d, b);
            else                   ref_mem[a] = lane_merge(16'h0000, d, b);
        end
    endtask

    task automatic do_read(input int a);
        cs_n = 1'b0;
        we_n = 1'b1;
        oe_n = 1'b0;
        addr = 18'(a);
        be   = 2'b00;
        tick();
    endtask

    task automatic idle();
        cs_n = 1'b1;
        we_n = 1'b1;
        oe_n = 1'b1;
        tick();
    endtask

    initial begin
        int          a;
        logic [15:0] d;
        logic [1:0]  b;

        rstn  = 1'b0;
        cs_n  = 1'b1;
        we_n  = 1'b1;
        oe_n  = 1'b1;
        addr  = '0;
        wdata = '0;
        be    = '0;
        repeat (5) tick();
        check("reset_idle_z", rdata, RELEASED);
        cs_n = 1'b0;
        oe_n = 1'b0;
        #1;
        check("reset_drive_zero", rdata, 16'h0000);
        cs_n = 1'b1;
        oe_n = 1'b1;
        rstn = 1'b1;
        tick();

        do_write(32'h10, 16'h1234, 2'b11);
        do_read(32'h10);
        check("full_write", rdata, 16'h1234);

        do_write(32'h20, 16'hAAAA, 2'b11);
        do_write(32'h20, 16'h5566, 2'b01);
        do_read(32'h20);
        check("partial_lo", rdata, 16'hAA66);
        do_write(32'h20, 16'h77C3, 2'b10);
        do_read(32'h20);
        check("partial_hi", rdata, 16'h7766);

        do_write(32'h10, 16'hFFFF, 2'b00);
        do_read(32'h10);
        check("be_zero_noop", rdata, 16'h1234);

        oe_n = 1'b1;
        #1;
        check("oe_high_z", rdata, RELEASED);
        oe_n = 1'b0;
        #1;
        check("oe_same_cycle", rdata, 16'h1234);
        we_n = 1'b0;
        #1;
        check("we_forces_z", rdata, RELEASED);
        we_n = 1'b1;
        #1;

        do_write(DEPTH + 32'h10, 16'hBEEF, 2'b11);
        do_read(32'h10);
        check("oor_write_ignored", rdata, 16'h1234);
        do_read(DEPTH + 5);
        check("oor_read_zero", rdata, 16'h0000);

        do_read(32'h20);
        check("pre_reset_read", rdata, 16'h7766);
        rstn = 1'b0;
        #1;
        check("midreset_clear", rdata, 16'h0000);
        rstn = 1'b1;
        #1;
        do_read(32'h20);
        check("retained_after_reset", rdata, 16'h7766);
        idle();

        for (int n = 0; n < 200; n++) begin
            if (n == 0)      a = 0;
            else if (n == 1) a = DEPTH - 1;
            else             a = int'($urandom_range(DEPTH - 1, 0));
            if (!ref_mem.exists(a)) do_write(a, 16'($urandom), 2'b11);
            d = 16'($urandom);
            b = 2'($urandom_range(3, 0));
            do_write(a, d, b);
            we_n = 1'b1;
            oe_n = 1'b0;
            #1;
            check("rand_write_through", rdata, ref_mem[a]);
            do_read(a);
            check("rand_read_after_write", rdata, ref_mem[a]);
            if (n % 16 == 0) idle();
        end
        idle();
        check("final_idle_z", rdata, RELEASED);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
